// File: rtl/res_accum_if.sv
// ============================================================================
// res_accum_if : sample-in / batch-sum-out handshake bundle.   Rev 1.0
// ============================================================================
`default_nettype none

interface res_accum_if #(
  parameter int W     = 4,
  parameter int SUM_W = W + 4
);
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             out_valid;
  logic [SUM_W-1:0] out_sum;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

`default_nettype wire

// File: rtl/res_accum.sv
// ============================================================================
// res_accum : sums each batch of N unsigned samples into one output.  Rev 1.0
// ============================================================================
`default_nettype none

module res_accum #(
  parameter int N     = 8,
  parameter int W     = 4,
  parameter int SUM_W = W + 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  input  wire logic     clr,
  res_accum_if.slave    bus
);
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;

  logic             last;
  logic             in_ready;
  logic             accept;
  logic             xfer;
  logic [SUM_W-1:0] sum_next;

  // The final sample of a batch is only stalled when its result would
  // overwrite a still-pending sum; earlier samples always flow.
  assign last     = (cnt_q == C_LAST);
  assign in_ready = !(last && out_valid_q && !bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign xfer     = out_valid_q && bus.out_ready;
  assign sum_next = acc_q + SUM_W'(bus.in_data);

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    if (clr) begin
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (xfer) begin
        out_valid_d = 1'b0;
      end
      // A completing batch overrides the drop above, giving bubble-free output.
      if (accept) begin
        if (last) begin
          out_sum_d   = sum_next;
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
        end else begin
          acc_d = sum_next;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;

endmodule

`default_nettype wire

// File: tb/tb_res_accum.sv
// ============================================================================
// tb_res_accum : vector table, directed corners and random run vs a model.
// ============================================================================
`default_nettype none

module tb_res_accum;
  localparam int N     = 8;
  localparam int W     = 4;
  localparam int SUM_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  res_accum_if #(.W(W), .SUM_W(SUM_W)) bus ();

  res_accum #(.N(N), .W(W), .SUM_W(SUM_W)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: the current batch is a queue of accepted samples, plus one
  // pending-result slot.
  int mq[$];
  bit m_pend;
  int m_sum;

  bit last_ir, last_ov;
  int last_os;

  typedef struct {
    bit             v;
    logic [W-1:0]   d;
    bit             ordy;
    bit             c;
    bit             eir;
    bit             eov;
    int             esum;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input bit v, input int d, input bit ordy, input bit c,
                              input bit eir, input bit eov, input int esum);
    vec_t e;
    e.v = v; e.d = W'(d); e.ordy = ordy; e.c = c;
    e.eir = eir; e.eov = eov; e.esum = esum;
    tbl.push_back(e);
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_pend = 1'b0;
    m_sum  = 0;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit v, input logic [W-1:0] d, input bit ordy, input bit c,
                      output bit eir, output bit eov, output int eos);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    clr           = c;
    #1;
    last_ir = bus.in_ready;
    eir = !(mq.size() == N - 1 && m_pend && !ordy);
    if (c) begin
      mq.delete();
      m_pend = 1'b0;
    end else begin
      if (m_pend && ordy) m_pend = 1'b0;
      if (v && eir) begin
        mq.push_back(int'(d));
        if (mq.size() == N) begin
          m_sum  = mq.sum();
          m_pend = 1'b1;
          mq.delete();
        end
      end
    end
    eov = m_pend;
    eos = m_sum;
    @(posedge clk);
    #1;
    last_ov = bus.out_valid;
    last_os = int'(bus.out_sum);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit ordy, input bit c,
                       input string tag);
    bit eir, eov;
    int eos;
    step(v, d, ordy, c, eir, eov, eos);
    check({tag, "_in_ready"},  int'(last_ir), int'(eir));
    check({tag, "_out_valid"}, int'(last_ov), int'(eov));
    check({tag, "_out_sum"},   last_os, eos);
  endtask

  initial begin
    bit eir, eov;
    int eos;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    model_reset();

    // Reset must act before any clock edge.
    #1 rst = 1'b0;
    #1;
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_sum",   int'(bus.out_sum),   0);
    check("reset_in_ready",  int'(bus.in_ready),  1);
    @(negedge clk);
    rst = 1'b1;

    // Basic batch 1..8 -> 36.
    for (int i = 1; i <= 8; i++) add(1, i, 1, 0, 1, (i == 8), (i == 8) ? 36 : 0);
    add(0, 0, 1, 0, 1, 0, 36);
    // Maximum value 8x15 -> 120.
    for (int i = 1; i <= 8; i++) add(1, 15, 1, 0, 1, (i == 8), (i == 8) ? 120 : 36);
    add(0, 0, 1, 0, 1, 0, 120);
    // Backpressure: batch A (sum 8) held, batch B of 2s streams behind it.
    for (int i = 1; i <= 8; i++) add(1, 1, 0, 0, 1, (i == 8), (i == 8) ? 8 : 120);
    for (int i = 1; i <= 7; i++) add(1, 2, 0, 0, 1, 1, 8);
    add(1, 2, 0, 0, 0, 1, 8);
    add(1, 2, 0, 0, 0, 1, 8);
    add(1, 2, 1, 0, 1, 1, 16);
    add(0, 0, 1, 0, 1, 0, 16);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].ordy, tbl[i].c, eir, eov, eos);
      check($sformatf("tbl%0d_in_ready", i),  int'(last_ir), int'(tbl[i].eir));
      check($sformatf("tbl%0d_out_valid", i), int'(last_ov), int'(tbl[i].eov));
      check($sformatf("tbl%0d_out_sum", i),   last_os,       tbl[i].esum);
    end

    // Clear with a simultaneous valid sample: that sample is dropped.
    for (int i = 0; i < 5; i++) drive(1, 4'd3, 1, 0, "clr_pre");
    drive(1, 4'd9, 1, 1, "clr_edge");
    check("clr_out_valid", int'(last_ov), 0);
    for (int i = 0; i < 7; i++) drive(1, 4'd4, 1, 0, "clr_post");
    check("clr_no_early_valid", int'(last_ov), 0);
    drive(1, 4'd4, 1, 0, "clr_last");
    check("clr_batch_valid", int'(last_ov), 1);
    check("clr_batch_sum", last_os, 32);
    drive(0, 4'd0, 1, 0, "clr_idle");

    // Asynchronous reset with a pending output and cnt=3.
    for (int i = 0; i < 11; i++) drive(1, 4'd1, 0, 0, "ar_pre");
    check("ar_pending_valid", int'(last_ov), 1);
    check("ar_pending_sum", last_os, 8);
    #2 rst = 1'b0;
    #1;
    check("ar_async_out_valid", int'(bus.out_valid), 0);
    check("ar_async_out_sum",   int'(bus.out_sum),   0);
    check("ar_async_in_ready",  int'(bus.in_ready),  1);
    model_reset();
    @(posedge clk);
    #1;
    check("ar_hold_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) drive(1, 4'd5, 1, 0, "ar_post");
    check("ar_batch_valid", int'(last_ov), 1);
    check("ar_batch_sum", last_os, 40);

    // Random gapped traffic with junk data, backpressure and rare clears.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0), W'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/res_accum.md
RES_ACCUM -- requirements
Module: res_accum

Interface
- REQ-001: Parameter N, default 8, is the number of samples per batch; legal range is 2..16.
- REQ-002: Parameter W, default 4, is the width of each input sample.
- REQ-003: Parameter SUM_W, default W+4, is the width of the batch sum; it SHALL be at least W+clog2(N).
- REQ-004: clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
- REQ-005: rst, input, 1 bit: asynchronous, active-low reset; 0 SHALL reset the block immediately, regardless of clk.
- REQ-006: clr, input, 1 bit: synchronous clear, active high.
- REQ-007: in_valid, input, 1 bit: in_data is valid.
- REQ-008: in_data, input, W bits: unsigned sample, for example a registered adder result.
- REQ-009: in_ready, output, 1 bit: the block can accept a sample this cycle.
- REQ-010: out_valid, output, 1 bit: out_sum holds a completed batch sum.
- REQ-011: out_sum, output, SUM_W bits: unsigned sum of the N samples in one batch.
- REQ-012: out_ready, input, 1 bit: the consumer accepts out_sum this cycle.

Function
- REQ-013: A sample SHALL be accepted in a cycle only when in_valid=1 and in_ready=1 at the rising clk edge.
- REQ-014: Internal state SHALL be acc (SUM_W bits) and cnt (0..N-1).
  - On each non-final accept: acc <= acc + in_data; cnt <= cnt + 1.
- REQ-015: An accept with cnt=N-1 SHALL complete the batch:
  - out_sum <= acc + in_data;
  - out_valid <= 1;
  - acc <= 0; cnt <= 0.
- REQ-016: Result latency SHALL be exactly 1 cycle: out_valid rises on the edge that accepts the Nth sample.
- REQ-017: An output transfer SHALL occur when out_valid=1 and out_ready=1 at the rising clk edge.
  - After the transfer, out_valid SHALL drop to 0 unless a new batch completes on the same edge.
- REQ-018: While out_valid=1 and out_ready=0, out_sum and out_valid SHALL hold stable.
- REQ-019: Accumulation of the next batch SHALL continue while an output is pending.
- REQ-020: in_ready SHALL equal NOT(cnt=N-1 AND out_valid=1 AND out_ready=0).
  - in_ready is combinational from state and out_ready only.
  - It SHALL NOT depend on in_valid.
- REQ-021: When a batch completes on the same edge as an output transfer, out_sum SHALL load the new sum and out_valid SHALL stay 1, with no bubble.
- REQ-022: Arithmetic SHALL be unsigned, with in_data zero-extended to SUM_W.
  - No overflow is possible within the legal parameters; the maximum sum is N*(2^W-1).
- REQ-023: clr=1 SHALL set acc=0, cnt=0 and out_valid=0 on that edge.
  - clr SHALL take priority over any simultaneous accept or transfer.
  - The sample presented in that cycle SHALL be discarded.
- REQ-024: in_data SHALL be ignored whenever no accept occurs.

Reset
- REQ-025: While rst=0: acc=0, cnt=0, out_valid=0, out_sum=0.
  - in_ready SHALL read 1 during reset.
- REQ-026: Reset asserted mid-batch or with an output pending SHALL discard all partial and pending data.
- REQ-027: After rst is released, the first accepted sample SHALL be sample 1 of a new batch.
- REQ-028: Deassertion of rst is synchronised externally; the block requires no reset-release handling of its own.

Verification
- REQ-029: Basic batch. With N=8 and out_ready=1, send samples 1,2,3,4,5,6,7,8 back to back.
  - Required: out_valid=1 for exactly one cycle, on the edge after sample 8 is accepted, with out_sum=36.
- REQ-030: Maximum value. Send eight samples of 15.
  - Required: out_sum=120; no wrap occurs.
- REQ-031: Backpressure. Hold out_ready=0 after batch A (sum 8) and stream batch B continuously.
  - Required: batch B samples 1..7 are accepted.
  - in_ready=0 while sample 8 waits.
  - out_sum stays 8 throughout.
  - Raising out_ready transfers 8; on the same edge sample 8 is accepted and out_sum becomes batch B's sum, with out_valid held at 1.
- REQ-032: Gapped input. Toggle in_valid randomly over 3 batches while driving junk in_data when invalid.
  - Required: each sum counts only the accepted samples.
- REQ-033: Clear. After 5 samples accepted, assert clr in the same cycle as in_valid=1.
  - Required: that sample is dropped.
  - The next 8 accepted samples form a complete batch.
- REQ-034: Asynchronous reset. Pull rst low between clock edges while out_valid=1 and cnt=3.
  - Required: out_valid and out_sum go to 0 immediately, without waiting for a clock edge.
  - After release, 8 further samples produce the correct sum.
